// File: rtl/chaff_serializer_if.sv
// chaff_serializer_if -- package-in / beat-out bus for chaff_serializer.
//   slave  modport: serializer side (consumes packages, produces beats)
//   master modport: producer/consumer side (drives packages and out_ready)
// Signals:
//   in_valid/in_ready  : package handshake
//   in_pkg             : BW*(NB+1) package vector, block i = in_pkg[i*BW +: BW]
//   mac_key            : tag key, sampled together with in_pkg
//   out_valid/out_ready: beat handshake
//   out_data/out_seq/out_tag/out_last : beat payload
//   busy               : a message is in flight
interface chaff_serializer_if #(
  parameter int unsigned BW = 64,
  parameter int unsigned NB = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BW*(NB+1)-1:0]  in_pkg;
  logic [BW-1:0]         mac_key;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW-1:0]         out_data;
  logic [3:0]            out_seq;
  logic [7:0]            out_tag;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  in_valid, in_pkg, mac_key, out_ready,
    output in_ready, out_valid, out_data, out_seq, out_tag, out_last, busy
  );

  modport master (
    output in_valid, in_pkg, mac_key, out_ready,
    input  in_ready, out_valid, out_data, out_seq, out_tag, out_last, busy
  );
endinterface

// File: rtl/chaff_serializer.sv
// chaff_serializer -- emits the noofblocks+1 blocks of a captured AONT
// package as tagged "wheat" beats, optionally interleaving LFSR-generated
// "chaff" beats (at most one before each wheat beat).
// Wheat tag = T(block, seq), chaff tag = ~T(chaff data, seq), where
// T(d,s) = XOR of the bytes of (d ^ key) ^ {s,s}.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : chaff_serializer_if.slave (package in, beats out, busy)
// Parameters: lslen (symbols/block), lslenlog (bits/symbol),
//   noofblocks (package holds noofblocks+1 blocks), LFSR_SEED (nonzero).
// Configuration: define CHAFF_SERIALIZER_CHAFF_EN to enable chaff
//   insertion; otherwise exactly noofblocks+1 wheat beats are emitted.
module chaff_serializer #(
  parameter int unsigned lslen      = 16,
  parameter int unsigned lslenlog   = 4,
  parameter int unsigned noofblocks = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic             clk,
  input logic             rstn,
  chaff_serializer_if.slave bus
);
  localparam int unsigned BW       = lslen * lslenlog;
  localparam int unsigned PW       = BW * (noofblocks + 1);
  localparam logic [3:0]  LAST_SEQ = 4'(noofblocks);

`ifdef CHAFF_SERIALIZER_CHAFF_EN
  localparam int unsigned REP = BW / 16;
  typedef enum logic [1:0] {IDLE, WHEAT, CHAFF} state_t;
`else
  typedef enum logic [1:0] {IDLE, WHEAT} state_t;
`endif

  state_t          state, state_d;
  logic [3:0]      seq, seq_d;
  logic [15:0]     lfsr, lfsr_d, lfsr_adv;
  logic [PW-1:0]   pkg_q;
  logic [BW-1:0]   key_q;
  logic            capture;
  logic [BW-1:0]   wheat_data;

  logic            o_valid;
  logic [BW-1:0]   o_data;
  logic [3:0]      o_seq;
  logic [7:0]      o_tag;
  logic            o_last;

  function automatic logic [7:0] tag_fn(input logic [BW-1:0] d,
                                        input logic [BW-1:0] k,
                                        input logic [3:0]    s);
    logic [BW-1:0] x;
    logic [7:0]    acc;
    x   = d ^ k;
    acc = {s, s};
    for (int unsigned i = 0; i < BW / 8; i++) begin
      acc ^= x[i*8 +: 8];
    end
    return acc;
  endfunction

  // Fibonacci taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15.
  assign lfsr_adv   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign wheat_data = pkg_q[32'(seq) * BW +: BW];

`ifdef CHAFF_SERIALIZER_CHAFF_EN
  logic [BW-1:0] chaff_data;
  assign chaff_data = {REP{lfsr}};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      seq   <= '0;
      lfsr  <= LFSR_SEED;
      pkg_q <= '0;
      key_q <= '0;
    end else begin
      state <= state_d;
      seq   <= seq_d;
      lfsr  <= lfsr_d;
      if (capture) begin
        pkg_q <= bus.in_pkg;
        key_q <= bus.mac_key;
      end
    end
  end

  always_comb begin
    state_d = state;
    seq_d   = seq;
    lfsr_d  = lfsr;
    capture = 1'b0;
    o_valid = 1'b0;
    o_data  = '0;
    o_seq   = '0;
    o_tag   = '0;
    o_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          seq_d   = '0;
`ifdef CHAFF_SERIALIZER_CHAFF_EN
          state_d = lfsr[0] ? CHAFF : WHEAT;
`else
          state_d = WHEAT;
`endif
        end
      end
      WHEAT: begin
        o_valid = 1'b1;
        o_data  = wheat_data;
        o_seq   = seq;
        o_tag   = tag_fn(wheat_data, key_q, seq);
        o_last  = (seq == LAST_SEQ);
        if (bus.out_ready) begin
          lfsr_d = lfsr_adv;
          if (seq == LAST_SEQ) begin
            state_d = IDLE;
          end else begin
            seq_d = seq + 4'd1;
            // Chaff decision uses the LFSR value that the next beat will see.
`ifdef CHAFF_SERIALIZER_CHAFF_EN
            state_d = lfsr_adv[0] ? CHAFF : WHEAT;
`else
            state_d = WHEAT;
`endif
          end
        end
      end
`ifdef CHAFF_SERIALIZER_CHAFF_EN
      CHAFF: begin
        o_valid = 1'b1;
        o_data  = chaff_data;
        o_seq   = seq;
        o_tag   = ~tag_fn(chaff_data, key_q, seq);
        if (bus.out_ready) begin
          lfsr_d  = lfsr_adv;
          state_d = WHEAT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = o_valid;
  assign bus.out_data  = o_data;
  assign bus.out_seq   = o_seq;
  assign bus.out_tag   = o_tag;
  assign bus.out_last  = o_last;
endmodule
